// File: rtl/mul_ctrl_pkg.sv
// Shared types and constants for the sequenced 8x8 multiplier arbiter.
package mul_ctrl_pkg;

    localparam int unsigned SLICE_W = 4;
    localparam int unsigned OP_W    = 8;
    localparam int unsigned PROD_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
    } operand_t;

    // Left shift applied to each 4x4 partial product, indexed by step.
    localparam int unsigned STEP_SHIFT [4] = '{0, 4, 4, 8};

    function automatic int unsigned step_shift(input logic [1:0] step);
        return STEP_SHIFT[step];
    endfunction

endpackage

// File: rtl/mul4x4_core.sv
// Combinational 4x4 -> 8-bit unsigned multiplier: AND-gated partial-product rows plus adder.
module mul4x4_core
    import mul_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0]   a,
    input  logic [SLICE_W-1:0]   b,
    output logic [2*SLICE_W-1:0] p
);

    localparam int unsigned P_W = 2 * SLICE_W;

    logic [P_W-1:0] row [SLICE_W];

    for (genvar i = 0; i < SLICE_W; i++) begin : g_row
        assign row[i] = P_W'(a & {SLICE_W{b[i]}}) << i;
    end

    always_comb begin
        p = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            p = p + row[i];
        end
    end

endmodule

// File: rtl/mul8_seq_arbiter.sv
// Round-robin arbiter sharing one 4x4 multiplier core; each 8x8 product takes four core steps.
module mul8_seq_arbiter
    import mul_ctrl_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned ID_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*OP_W-1:0] req_a,
    input  logic [NREQ*OP_W-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [PROD_W-1:0]    rsp_prod,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 busy
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [1:0]          step_q, step_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    operand_t            op_q, op_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                busy_q, busy_d;

    logic [ID_W-1:0]     grant;
    logic                found;
    logic [NREQ-1:0]     req_ready_c;
    logic [NREQ-1:0]     rot_valid;
    int unsigned         idx;

    logic [SLICE_W-1:0]   core_a, core_b;
    logic [2*SLICE_W-1:0] core_p;
    logic [PROD_W-1:0]    pp_shifted;

    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        grant     = '0;
        found     = 1'b0;
        idx       = 0;
        rot_valid = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx       = (32'(rr_ptr_q) + k) % NREQ;
            rot_valid = req_valid >> idx;
            if (!found && rot_valid[0]) begin
                grant = ID_W'(idx);
                found = 1'b1;
            end
        end
    end

    // step[1] picks the high nibble of a, step[0] the high nibble of b.
    assign core_a = step_q[1] ? op_q.a[7:4] : op_q.a[3:0];
    assign core_b = step_q[0] ? op_q.b[7:4] : op_q.b[3:0];

    mul4x4_core u_core (
        .a (core_a),
        .b (core_b),
        .p (core_p)
    );

    assign pp_shifted = PROD_W'(core_p) << step_shift(step_q);

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        step_d      = step_q;
        acc_d       = acc_q;
        op_d        = op_q;
        prod_d      = prod_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready_c = '0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    req_ready_c = NREQ'(1) << grant;
                    op_d.a      = OP_W'(req_a >> (32'(grant) * OP_W));
                    op_d.b      = OP_W'(req_b >> (32'(grant) * OP_W));
                    id_d        = grant;
                    acc_d       = '0;
                    step_d      = 2'd0;
                    rr_ptr_d    = ID_W'((32'(grant) + 1) % NREQ);
                    state_d     = MUL;
                end
            end
            MUL: begin
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    prod_d      = acc_q + pp_shifted;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            step_q      <= 2'd0;
            acc_q       <= '0;
            op_q        <= '0;
            prod_q      <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            prod_q      <= prod_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Accept strobe is a same-cycle reply to req_valid; held low while in reset.
    assign req_ready = rst_n ? req_ready_c : '0;
    assign rsp_valid = rsp_valid_q;
    assign rsp_prod  = prod_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul8_seq_arbiter.sv
// Directed bench for mul8_seq_arbiter (NREQ=2): latency, products, round-robin, backpressure, reset.
module tb_mul8_seq_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_prod;
    logic [0:0]  rsp_id;
    logic        busy;

    int tests;
    int fails;

    mul8_seq_arbiter #(.NREQ(2), .ID_W(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle (negedge) of the handshake cycle T; returns mid-cycle T+6+hold.
    task automatic do_op(input string tag, input logic [1:0] vmask, input logic [1:0] exp_ready,
                         input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                         input logic exp_id, input int hold);
        logic ok;
        req_a[exp_id*8 +: 8] = a;
        req_b[exp_id*8 +: 8] = b;
        req_valid = vmask;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(exp_ready));
        @(negedge clk);
        ok = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (!(busy === 1'b1 && rsp_valid === 1'b0 && req_ready === 2'b00)) ok = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_mulphase"}, 32'(ok), 32'd1);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_prod"}, 32'(rsp_prod), 32'(exp_p));
        chk({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        chk({tag, "_busy_done"}, 32'(busy), 32'd1);
        chk({tag, "_noaccept_done"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            ok = (rsp_valid === 1'b1) && (rsp_prod === exp_p) && (rsp_id === exp_id)
                 && (req_ready === 2'b00) && (busy === 1'b1);
            chk({tag, "_hold"}, 32'(ok), 32'd1);
        end
        rsp_ready = 1'b1;
        #1;
        chk({tag, "_noaccept_hs"}, 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_prod_kept"}, 32'(rsp_prod), 32'(exp_p));
    endtask

    initial begin
        logic ok;
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values, with requests pending
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_prod", 32'(rsp_prod), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        rst_n     = 1'b1;
        @(negedge clk);
        chk("idle_hold_busy", 32'(busy), 32'd0);

        // Single op: FF*FF from req0
        do_op("single", 2'b01, 2'b01, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 0);
        req_valid = 2'b00;
        @(negedge clk);

        // Fairness: only req1 (rr_ptr starts at 1, then wraps to 0 each time)
        do_op("fair0", 2'b10, 2'b10, 8'h03, 8'h05, 16'h000F, 1'b1, 0);
        do_op("fair1", 2'b10, 2'b10, 8'h10, 8'h10, 16'h0100, 1'b1, 0);
        do_op("fair2", 2'b10, 2'b10, 8'hFF, 8'h01, 16'h00FF, 1'b1, 0);

        // Contention: both held, grant order 0,1,0,1
        req_a = 16'hAB12;
        req_b = 16'hCD34;
        do_op("cont0", 2'b11, 2'b01, 8'h12, 8'h34, 16'h03A8, 1'b0, 0);
        do_op("cont1", 2'b11, 2'b10, 8'hAB, 8'hCD, 16'h88EF, 1'b1, 0);
        do_op("cont2", 2'b11, 2'b01, 8'h12, 8'h34, 16'h03A8, 1'b0, 0);
        do_op("cont3", 2'b11, 2'b10, 8'hAB, 8'hCD, 16'h88EF, 1'b1, 0);

        // Edge operands, one with 7 cycles of backpressure; accept right after handshake
        do_op("zero", 2'b01, 2'b01, 8'h00, 8'hAB, 16'h0000, 1'b0, 0);
        do_op("bp", 2'b01, 2'b01, 8'h0F, 8'hF0, 16'h0E10, 1'b0, 7);
        do_op("pow2", 2'b01, 2'b01, 8'h80, 8'h02, 16'h0100, 1'b0, 0);

        // Reset during MUL step 2 (rr_ptr is 1 before the reset)
        req_a[7:0] = 8'h77;
        req_b[7:0] = 8'h99;
        req_valid  = 2'b01;
        @(negedge clk);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_valid", 32'(rsp_valid), 32'd0);
        chk("mrst_prod", 32'(rsp_prod), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!(rsp_valid === 1'b0 && busy === 1'b0)) ok = 1'b0;
        end
        chk("mrst_no_rsp", 32'(ok), 32'd1);
        do_op("post_rst", 2'b11, 2'b01, 8'h12, 8'h34, 16'h03A8, 1'b0, 0);
        req_valid = 2'b00;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mul8_seq_arbiter.md
Name: mul8_seq_arbiter

Overview:
- Shares one combinational 4x4 unsigned multiplier core between NREQ requesters.
- Computes 8x8 -> 16-bit unsigned products by sequencing four 4x4 partial products through the core and accumulating them.
- Sits between requester datapaths and the small multiplier array. It trades area for a fixed 5-cycle latency per operation.

Parameters:
- NREQ, 2, number of requesters; legal range 2..4.
- ID_W, 1, width of the response requester ID; must equal max(1, ceil(log2(NREQ))).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operation valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high in any cycle.
- req_a  input  NREQ*8  packed multiplicands; requester i uses bits [8i+7:8i].
- req_b  input  NREQ*8  packed multipliers; same packing as req_a.
- rsp_valid  output  1  product valid.
- rsp_ready  input  1  consumer accept.
- rsp_prod  output  16  unsigned product.
- rsp_id  output  ID_W  index of the requester that owns rsp_prod.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, rr_ptr=0, step=0, acc=0. Outputs: rsp_valid=0, rsp_prod=0, rsp_id=0, busy=0, req_ready=0.
- States: IDLE, MUL, DONE.
- Arbitration:
  - Round-robin, evaluated only in IDLE.
  - grant = first i with req_valid[i], searching from rr_ptr upward and wrapping.
  - req_ready[grant]=1 only in IDLE with some req_valid high. req_ready=0 in MUL and DONE.
- Accept: in IDLE, if req_valid[grant], do all of the following in one cycle:
  - latch a, b and id=grant;
  - set acc=0, step=0, rr_ptr=(grant+1) mod NREQ;
  - go to MUL.
- rr_ptr advances only on accept. With no requests, IDLE holds and rr_ptr is unchanged.
- MUL steps (one core evaluation per cycle):
  - step 0: a[3:0]*b[3:0], shift 0
  - step 1: a[3:0]*b[7:4], shift 4
  - step 2: a[7:4]*b[3:0], shift 4
  - step 3: a[7:4]*b[7:4], shift 8
- Accumulation:
  - acc <= acc + (pp << shift), computed 16 bits wide. No overflow is possible because the maximum is 0xFE01.
  - After step 3: rsp_prod <= final sum, rsp_id <= id, rsp_valid <= 1, go to DONE.
- Latency: handshake in cycle T gives rsp_valid=1 at cycle T+5. It is fixed and does not depend on the data. Zero operands take no shortcut.
- DONE:
  - Hold rsp_valid, rsp_prod and rsp_id stable while rsp_ready=0.
  - When rsp_ready=1: rsp_valid <= 0 and go to IDLE.
  - rsp_prod and rsp_id keep their last values after the handshake.
  - No new request is accepted in the same cycle as the response handshake. Minimum spacing between accepts is 6 cycles.
- Requests are non-preemptive. A requester deasserting req_valid while the operation is in MUL or DONE does not affect it.
- req_valid held with req_ready=0 is simply waiting. The requester must keep req_a/req_b stable until its req_ready handshake; only the handshake-cycle values are used.
- Reset mid-operation: the in-flight product is discarded, no response is issued, and all state returns to reset values.
- Simultaneous rsp_ready and new req_valid in DONE: only the response completes. The request waits for IDLE.
- busy = (state != IDLE).

Decomposition:
- Package mul_ctrl_pkg holds:
  - the state enum {IDLE, MUL, DONE};
  - constants SLICE_W=4, OP_W=8, PROD_W=16;
  - the step-to-shift table {0,4,4,8}.
- Sub-module mul4x4_core: combinational 4x4 -> 8-bit unsigned multiplier (partial-product array plus final adder), instantiated once.
- The arbiter pointer logic is small and stays inline.

Test Plan:
- Single op: req0 a=0xFF, b=0xFF, accepted at T -> rsp_valid at T+5 with rsp_prod=0xFE01, rsp_id=0; busy high T+1..T+5.
- Contention (NREQ=2): req_valid=2'b11 held, each response accepted immediately -> grant order 0,1,0,1. Products: req0 a=0x12,b=0x34 -> 0x03A8; req1 a=0xAB,b=0xCD -> 0x88EF.
- Backpressure: rsp_ready=0 for 7 cycles after rsp_valid -> rsp_prod/rsp_id stable, req_ready stays 0; rsp_ready=1 -> rsp_valid drops next cycle, next accept the cycle after.
- Edge values: 0x00*0xAB -> 0x0000 at T+5; 0x80*0x02 -> 0x0100; 0x0F*0xF0 -> 0x0E10.
- Reset mid-op: rst_n low during MUL step 2 -> all outputs 0 immediately, no response after release; the next request after release is granted to req0 (rr_ptr=0).
- Fairness: only req1 valid for 3 ops -> all served, rr_ptr wraps to 0 each time, no idle grant to req0.
